window_3x3_gen: RTL and testbench

- Builds a 3x3 pixel neighbourhood from a raster-order 12-bit pixel stream, using two line buffers and a 3x3 tap register array.
- Sits directly upstream of the Gaussian filter and other 3x3 kernels.
- Presents nine window taps plus valid, frame-marker, coordinate and edge sideband, all registered.
- Zero-pads taps that fall outside the image.

---
 rtl/window_3x3_gen_if.sv | 37 +++
 rtl/window_3x3_gen.sv | 197 +++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream bundle for the 3x3 window generator: raster input side and
// registered window/sideband output side.
interface window_3x3_gen_if #(
    parameter int DATA_W = 12,
    parameter int XW     = 9,
    parameter int YW     = 8
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_sof;
    logic              out_eof;
    logic              out_edge;
    logic [XW-1:0]     out_x;
    logic [YW-1:0]     out_y;
    logic [DATA_W-1:0] PixelData_00, PixelData_01, PixelData_02;
    logic [DATA_W-1:0] PixelData_10, PixelData_11, PixelData_12;
    logic [DATA_W-1:0] PixelData_20, PixelData_21, PixelData_22;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_sof, out_eof, out_edge, out_x, out_y,
        input  PixelData_00, PixelData_01, PixelData_02,
        input  PixelData_10, PixelData_11, PixelData_12,
        input  PixelData_20, PixelData_21, PixelData_22
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_sof, out_eof, out_edge, out_x, out_y,
        output PixelData_00, PixelData_01, PixelData_02,
        output PixelData_10, PixelData_11, PixelData_12,
        output PixelData_20, PixelData_21, PixelData_22
    );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers feed a 3x3 tap array; taps
// outside the image are zeroed at the output. Two-cycle latency: stage 1
// holds the line-buffer reads, stage 2 registers the masked window.
module window_3x3_gen #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DATA_W = 12,
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    window_3x3_gen_if.slave       bus
);
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t            r_state, w_state_next;
    logic [XW-1:0]     r_col, w_col_next, w_acc_x;
    logic [YW-1:0]     r_row, w_row_next, w_acc_y;
    logic              w_accept, w_last;

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_lb0_rd, r_lb1_rd;

    logic              r_s1_valid, r_s1_sof, r_s1_eof;
    logic [XW-1:0]     r_s1_x;
    logic [YW-1:0]     r_s1_y;
    logic [DATA_W-1:0] r_s1_data;

    logic [DATA_W-1:0] r_tap      [3][3];
    logic [DATA_W-1:0] w_tap_next [3][3];
    logic [DATA_W-1:0] w_tap_mask [3][3];
    logic [DATA_W-1:0] w_new_col  [3];
    logic [2:0]        w_col_kill, w_row_kill;

    logic              r_out_valid, r_out_sof, r_out_eof, r_out_edge;
    logic [XW-1:0]     r_out_x;
    logic [YW-1:0]     r_out_y;
    logic [DATA_W-1:0] r_out_tap [3][3];

    // State and raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
            r_row   <= w_row_next;
        end
    end

    // Accept decision, position of the accepted pixel (sof forces 0,0) and next counters.
    always_comb begin
        w_accept     = bus.in_valid && ((r_state == ST_ACTIVE) || bus.in_sof);
        w_acc_x      = bus.in_sof ? '0 : r_col;
        w_acc_y      = bus.in_sof ? '0 : r_row;
        w_last       = (w_acc_x == XW'(IMG_W - 1)) && (w_acc_y == YW'(IMG_H - 1));
        w_state_next = r_state;
        w_col_next   = r_col;
        w_row_next   = r_row;
        if (w_accept) begin
            if (w_last) begin
                w_state_next = ST_IDLE;
                w_col_next   = '0;
                w_row_next   = '0;
            end else begin
                w_state_next = ST_ACTIVE;
                if (w_acc_x == XW'(IMG_W - 1)) begin
                    w_col_next = '0;
                    w_row_next = w_acc_y + 1'b1;
                end else begin
                    w_col_next = w_acc_x + 1'b1;
                    w_row_next = w_acc_y;
                end
            end
        end
    end

    // Line buffer 0 (row y-1): read-before-write at the accepted column.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0_rd       <= r_lb0[w_acc_x];
            r_lb0[w_acc_x] <= bus.in_data;
        end
    end

    // Line buffer 1 (row y-2): read on accept, refilled one cycle later from the lb0 read.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_lb1_rd <= r_lb1[w_acc_x];
        if (r_s1_valid)
            r_lb1[r_s1_x] <= r_lb0_rd;
    end

    // Stage 1: newest pixel and its sideband travel alongside the buffer reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sof  <= bus.in_sof;
                r_s1_eof  <= w_last;
                r_s1_x    <= w_acc_x;
                r_s1_y    <= w_acc_y;
                r_s1_data <= bus.in_data;
            end
        end
    end

    assign w_new_col[0] = r_lb1_rd;
    assign w_new_col[1] = r_lb0_rd;
    assign w_new_col[2] = r_s1_data;

    assign w_col_kill = {1'b0, (r_s1_x == '0), (r_s1_x < XW'(2))};
    assign w_row_kill = {1'b0, (r_s1_y == '0), (r_s1_y < YW'(2))};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign w_tap_next[gi][0] = r_tap[gi][1];
            assign w_tap_next[gi][1] = r_tap[gi][2];
            assign w_tap_next[gi][2] = w_new_col[gi];
            for (genvar gj = 0; gj < 3; gj++) begin : g_col
                assign w_tap_mask[gi][gj] = (w_row_kill[gi] || w_col_kill[gj]) ? '0 : w_tap_next[gi][gj];
            end
        end
    endgenerate

    // Tap array shifts left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_tap[i][j] <= '0;
        end else if (r_s1_valid) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_tap[i][j] <= w_tap_next[i][j];
        end
    end

    // Output stage: masked window plus sideband; sideband zero between pulses, taps hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_edge  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_out_tap[i][j] <= '0;
        end else if (r_s1_valid) begin
            r_out_valid <= 1'b1;
            r_out_sof   <= r_s1_sof;
            r_out_eof   <= r_s1_eof;
            r_out_edge  <= w_col_kill[0] || w_row_kill[0];
            r_out_x     <= r_s1_x;
            r_out_y     <= r_s1_y;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_out_tap[i][j] <= w_tap_mask[i][j];
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_edge  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_sof      = r_out_sof;
    assign bus.out_eof      = r_out_eof;
    assign bus.out_edge     = r_out_edge;
    assign bus.out_x        = r_out_x;
    assign bus.out_y        = r_out_y;
    assign bus.PixelData_00 = r_out_tap[0][0];
    assign bus.PixelData_01 = r_out_tap[0][1];
    assign bus.PixelData_02 = r_out_tap[0][2];
    assign bus.PixelData_10 = r_out_tap[1][0];
    assign bus.PixelData_11 = r_out_tap[1][1];
    assign bus.PixelData_12 = r_out_tap[1][2];
    assign bus.PixelData_20 = r_out_tap[2][0];
    assign bus.PixelData_21 = r_out_tap[2][1];
    assign bus.PixelData_22 = r_out_tap[2][2];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x3 image: a hand-derived vector table for
// one continuous frame, then directed and random sequences checked against an
// image-array reference model with a two-deep expected-output delay line.
module tb_window_3x3_gen;
    localparam int W = 4;
    localparam int H = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    window_3x3_gen_if #(.DATA_W(12), .XW(2), .YW(2)) bus ();

    window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(12), .XW(2), .YW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic            v;
        logic            sof;
        logic            eof;
        logic            edg;
        logic [1:0]      x;
        logic [1:0]      y;
        logic [8:0][11:0] t;
    } rec_t;

    typedef struct packed {
        logic        v;
        logic        sof;
        logic [11:0] d;
        logic        ev;
        logic        esof;
        logic        eeof;
        logic        eedg;
        logic [1:0]  ex;
        logic [1:0]  ey;
        logic [11:0] e00;
        logic [11:0] e11;
        logic [11:0] e22;
    } vec_t;

    int n_total = 0;
    int n_bad   = 0;

    rec_t              pipe0, pipe1;
    logic [8:0][11:0]  last_t;
    logic              m_active;
    int                m_col, m_row;
    logic [11:0]       img [H][W];

    function automatic rec_t dut_rec();
        rec_t a;
        a.v   = bus.out_valid;
        a.sof = bus.out_sof;
        a.eof = bus.out_eof;
        a.edg = bus.out_edge;
        a.x   = bus.out_x;
        a.y   = bus.out_y;
        a.t   = {bus.PixelData_22, bus.PixelData_21, bus.PixelData_20,
                 bus.PixelData_12, bus.PixelData_11, bus.PixelData_10,
                 bus.PixelData_02, bus.PixelData_01, bus.PixelData_00};
        return a;
    endfunction

    task automatic check_out();
        rec_t a;
        a = dut_rec();
        n_total++;
        if (a !== pipe1) begin
            n_bad++;
            $display("FAIL window t=%0t got v=%0b sof=%0b eof=%0b edge=%0b x=%0d y=%0d taps=%h want v=%0b sof=%0b eof=%0b edge=%0b x=%0d y=%0d taps=%h",
                     $time, a.v, a.sof, a.eof, a.edg, a.x, a.y, a.t,
                     pipe1.v, pipe1.sof, pipe1.eof, pipe1.edg, pipe1.x, pipe1.y, pipe1.t);
        end
    endtask

    // One clock: check outputs due now, drive inputs, update the model.
    task automatic step(input logic rst, input logic v, input logic sof, input logic [11:0] d);
        rec_t r;
        int x, y, xx, yy;
        check_out();
        reset        = rst;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = d;
        r = '0;
        if (rst) begin
            m_active = 1'b0;
            m_col    = 0;
            m_row    = 0;
            last_t   = '0;
            pipe0    = '0;
            pipe1    = '0;
        end else begin
            if (v && (m_active || sof)) begin
                x = sof ? 0 : m_col;
                y = sof ? 0 : m_row;
                img[y][x] = d;
                r.v   = 1'b1;
                r.sof = sof;
                r.eof = (x == W - 1) && (y == H - 1);
                r.edg = (x < 2) || (y < 2);
                r.x   = 2'(x);
                r.y   = 2'(y);
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++) begin
                        xx = x - 2 + cc;
                        yy = y - 2 + rr;
                        r.t[rr*3+cc] = (xx >= 0 && yy >= 0) ? img[yy][xx] : 12'h000;
                    end
                last_t = r.t;
                if (r.eof) begin
                    m_active = 1'b0;
                    m_col    = 0;
                    m_row    = 0;
                end else begin
                    m_active = 1'b1;
                    m_col    = (x == W - 1) ? 0 : x + 1;
                    m_row    = (x == W - 1) ? y + 1 : y;
                end
            end else begin
                r.t = last_t;
            end
            pipe1 = pipe0;
            pipe0 = r;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame_pix(input int p, input logic sof, input logic rnd);
        logic [11:0] d;
        d = rnd ? 12'($urandom) : 12'((p / W) * 16 + (p % W));
        step(1'b0, 1'b1, sof, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 12'($urandom));
    endtask

    vec_t tbl [14];
    int   cnt_v, cnt_eof;

    initial begin
        // Expected outputs seen at row i are for input pixel i-2 (2-cycle latency).
        //           v  sof d      ev esof eeof eedg ex ey   e00     e11     e22
        tbl[0]  = '{1, 1, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000};
        tbl[1]  = '{1, 0, 12'h001, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000};
        tbl[2]  = '{1, 0, 12'h002, 1, 1, 0, 1, 0, 0, 12'h000, 12'h000, 12'h000};
        tbl[3]  = '{1, 0, 12'h003, 1, 0, 0, 1, 1, 0, 12'h000, 12'h000, 12'h001};
        tbl[4]  = '{1, 0, 12'h010, 1, 0, 0, 1, 2, 0, 12'h000, 12'h000, 12'h002};
        tbl[5]  = '{1, 0, 12'h011, 1, 0, 0, 1, 3, 0, 12'h000, 12'h000, 12'h003};
        tbl[6]  = '{1, 0, 12'h012, 1, 0, 0, 1, 0, 1, 12'h000, 12'h000, 12'h010};
        tbl[7]  = '{1, 0, 12'h013, 1, 0, 0, 1, 1, 1, 12'h000, 12'h000, 12'h011};
        tbl[8]  = '{1, 0, 12'h020, 1, 0, 0, 1, 2, 1, 12'h000, 12'h001, 12'h012};
        tbl[9]  = '{1, 0, 12'h021, 1, 0, 0, 1, 3, 1, 12'h000, 12'h002, 12'h013};
        tbl[10] = '{1, 0, 12'h022, 1, 0, 0, 1, 0, 2, 12'h000, 12'h000, 12'h020};
        tbl[11] = '{1, 0, 12'h023, 1, 0, 0, 1, 1, 2, 12'h000, 12'h010, 12'h021};
        tbl[12] = '{0, 0, 12'h000, 1, 0, 0, 0, 2, 2, 12'h000, 12'h011, 12'h022};
        tbl[13] = '{0, 0, 12'h000, 1, 0, 1, 0, 3, 2, 12'h001, 12'h012, 12'h023};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        pipe0 = '0; pipe1 = '0; last_t = '0;
        m_active = 1'b0; m_col = 0; m_row = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                img[yy][xx] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b1, 1'b1, 12'h555);

        // Continuous frame, pixel = y*16+x, checked against the vector table.
        cnt_v = 0; cnt_eof = 0;
        for (int i = 0; i < 14; i++) begin
            n_total++;
            if (bus.out_valid !== tbl[i].ev || bus.out_sof !== tbl[i].esof ||
                bus.out_eof !== tbl[i].eeof || bus.out_edge !== tbl[i].eedg ||
                (tbl[i].ev && (bus.out_x !== tbl[i].ex || bus.out_y !== tbl[i].ey ||
                 bus.PixelData_00 !== tbl[i].e00 || bus.PixelData_11 !== tbl[i].e11 ||
                 bus.PixelData_22 !== tbl[i].e22))) begin
                n_bad++;
                $display("FAIL vec[%0d] got v=%0b sof=%0b eof=%0b edge=%0b x=%0d y=%0d p00=%h p11=%h p22=%h want v=%0b sof=%0b eof=%0b edge=%0b x=%0d y=%0d p00=%h p11=%h p22=%h",
                         i, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_edge, bus.out_x, bus.out_y,
                         bus.PixelData_00, bus.PixelData_11, bus.PixelData_22,
                         tbl[i].ev, tbl[i].esof, tbl[i].eeof, tbl[i].eedg, tbl[i].ex, tbl[i].ey,
                         tbl[i].e00, tbl[i].e11, tbl[i].e22);
            end
            if (bus.out_valid === 1'b1) cnt_v++;
            if (bus.out_eof === 1'b1) cnt_eof++;
            step(1'b0, tbl[i].v, tbl[i].sof, tbl[i].d);
        end
        n_total++;
        if (cnt_v != 12 || cnt_eof != 1) begin
            n_bad++;
            $display("FAIL pulse_count got valid=%0d eof=%0d want valid=12 eof=1", cnt_v, cnt_eof);
        end

        // Same frame with random gaps.
        for (int p = 0; p < W * H; p++) begin
            idle($urandom_range(0, 2));
            frame_pix(p, p == 0, 1'b0);
        end
        idle(3);

        // Pixels without sof while idle are dropped, then a sof frame.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 12'($urandom));
        for (int p = 0; p < W * H; p++) frame_pix(p, p == 0, 1'b1);
        idle(3);

        // Resync at input (2,1): abandoned frame, then a full fresh frame.
        for (int p = 0; p < W + 2; p++) frame_pix(p, p == 0, 1'b1);
        for (int p = 0; p < W * H; p++) frame_pix(p, p == 0, 1'b1);
        idle(3);

        // Reset on input (1,1), then valid pixels without sof.
        for (int p = 0; p < W + 1; p++) frame_pix(p, p == 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 12'($urandom));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 12'($urandom));
        idle(3);

        // Random traffic: gaps, occasional sof/resync and occasional reset.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 29) == 0), 12'($urandom));
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
